ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h8000_0000, address of the first fetch after reset.
REQ-002 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: mem_req_valid  out  1  instruction-memory read request valid.
REQ-005 Port: mem_req_ready  in  1  memory accepts the request.
REQ-006 Port: mem_req_addr  out  32  word address of the request.
REQ-007 Port: mem_rsp_valid  in  1  read data returned, one cycle pulse per accepted request.
REQ-008 Port: mem_rsp_data  in  32  returned instruction word.
REQ-009 Port: mem_rsp_err  in  1  access error, qualified by mem_rsp_valid.
REQ-010 Port: inst_valid  out  1  instruction offered to the decode stage.
REQ-011 Port: inst_ready  in  1  decode stage accepts the instruction.
REQ-012 Port: inst  out  32  instruction word to the decoder.
REQ-013 Port: inst_pc  out  32  PC of inst.
REQ-014 Port: redirect_valid  in  1  one-cycle branch/jump redirect from execute.
REQ-015 Port: redirect_pc  in  32  redirect target.
REQ-016 Port: fetch_fault  out  1  sticky fault indication.

Function
REQ-017 FSM states SHALL be REQ, WAIT, HOLD, FAULT.
REQ-018 REQ: mem_req_valid=1, mem_req_addr=pc; on mem_req_valid&&mem_req_ready go to WAIT.
REQ-019 mem_req_addr SHALL stay stable while mem_req_valid=1 and mem_req_ready=0.
REQ-020 WAIT: on mem_rsp_valid with kill=0 and err=0, latch inst<=mem_rsp_data and inst_pc<=pc, then go to HOLD.
REQ-021 HOLD: inst_valid=1; inst and inst_pc SHALL stay stable until inst_valid&&inst_ready.
REQ-022 On the HOLD handshake, pc<=pc+4 (mod 2^32, wraps at 32'hFFFF_FFFC) and go to REQ.
REQ-023 The minimum fetch-to-fetch period SHALL be 3 cycles (REQ, WAIT, HOLD), with one outstanding request at most.
REQ-024 Redirect in REQ before the handshake: pc<=redirect_pc; the stable-address rule is violated only when the request is not yet accepted; if accepted in the same cycle, the address sent is the old pc, and kill<=1.
REQ-025 Redirect in WAIT: kill<=1 and pc<=redirect_pc; the response arriving with kill=1 SHALL be discarded, kill cleared, and the FSM SHALL go to REQ.
REQ-026 Redirect and mem_rsp_valid in the same WAIT cycle: the response SHALL be discarded; go to REQ at redirect_pc.
REQ-027 Redirect in HOLD: inst_valid SHALL drop next cycle; pc<=redirect_pc; go to REQ.
REQ-028 If the inst handshake and a redirect occur in the same HOLD cycle, the instruction counts as consumed and the redirect target wins over pc+4.
REQ-029 redirect_pc[1:0]!=0 SHALL enter FAULT and SHALL issue no request.
REQ-030 mem_rsp_err with kill=0 SHALL enter FAULT; with kill=1 the response SHALL be discarded like data.
REQ-031 FAULT: fetch_fault=1, mem_req_valid=0, inst_valid=0; redirects are ignored; exit only by reset.
REQ-032 mem_rsp_valid outside WAIT SHALL be ignored.

Reset
REQ-033 rst_n=0 SHALL immediately force state=REQ, pc=RESET_PC, kill=0, inst=0, inst_pc=0, inst_valid=0, fetch_fault=0.
REQ-034 mem_req_valid SHALL be 0 while rst_n=0 and assert from the first clock edge after release.
REQ-035 Reset mid-transaction SHALL abandon any outstanding request; a stale mem_rsp_valid after release (state REQ) SHALL be ignored.

Verification
REQ-036 Reset release, memory always ready, rsp next cycle with 32'h0000_0513 -> request addr 8000_0000, inst=0000_0513, inst_pc=8000_0000, next request 8000_0004.
REQ-037 inst_ready held 0 for 5 cycles in HOLD -> inst and inst_pc stable, no new mem_req_valid, one fetch after ready.
REQ-038 Redirect to 8000_0100 while in WAIT, response 0x0000_0093 -> response dropped, inst_valid never 1 for it, next request addr 8000_0100.
REQ-039 Redirect to 8000_0203 -> fetch_fault=1, mem_req_valid=0 permanently until rst_n pulse, then fetch at RESET_PC.
REQ-040 mem_rsp_err=1 on first fetch -> FAULT; a later redirect to 8000_0000 produces no request.
REQ-041 pc=FFFF_FFFC handshake -> next request addr 0000_0000.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode handoff,
// redirect from execute and the sticky fault flag.
interface ifu_fetch_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  modport master (
    output mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
           inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
           inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch: REQ -> WAIT -> HOLD loop with
// redirect kill tracking and a sticky FAULT state left only by reset.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  ifu_fetch_if.master bus
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, FAULT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        kill_q, kill_d;
  logic        started_q;

  logic req_fire, redir_ok, redir_bad;

  // Request held back for the release cycle so valid rises on the first edge.
  assign bus.mem_req_valid = (state_q == REQ) && started_q;
  assign bus.mem_req_addr  = pc_q;
  assign bus.inst_valid    = (state_q == HOLD);
  assign bus.inst          = inst_q;
  assign bus.inst_pc       = inst_pc_q;
  assign bus.fetch_fault   = (state_q == FAULT);

  assign req_fire  = bus.mem_req_valid && bus.mem_req_ready;
  assign redir_ok  = bus.redirect_valid && (bus.redirect_pc[1:0] == 2'b00);
  assign redir_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    kill_d    = kill_q;
    case (state_q)
      REQ: begin
        if (redir_bad) begin
          state_d = FAULT;
        end else begin
          // Accepted in the same cycle as a redirect: old pc went out, so kill it.
          if (req_fire) begin
            state_d = WAIT;
            kill_d  = redir_ok;
          end
          if (redir_ok) pc_d = bus.redirect_pc;
        end
      end
      WAIT: begin
        if (redir_bad) begin
          state_d = FAULT;
        end else if (redir_ok) begin
          pc_d = bus.redirect_pc;
          if (bus.mem_rsp_valid) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (bus.mem_rsp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else if (bus.mem_rsp_err) begin
            state_d = FAULT;
          end else begin
            inst_d    = bus.mem_rsp_data;
            inst_pc_d = pc_q;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (redir_bad) begin
          state_d = FAULT;
        end else if (redir_ok) begin
          pc_d    = bus.redirect_pc;
          state_d = REQ;
        end else if (bus.inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = REQ;
        end
      end
      default: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      kill_q    <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      kill_q    <= kill_d;
      started_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a per-cycle vector table for the main flow
// plus hand-written sequences for stall, wrap, faults and reset.
module tb_ifu_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifu_fetch_if bus();

  ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct {
    logic        rdy, rv;
    logic [31:0] rd;
    logic        re, ir, xv;
    logic [31:0] xpc;
    logic        e_mv;
    logic [31:0] e_ma;
    logic        e_iv;
    logic [31:0] e_inst, e_ipc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic vec_t v(input logic rdy, input logic rv, input logic [31:0] rd,
                             input logic re, input logic ir, input logic xv,
                             input logic [31:0] xpc, input logic emv, input logic [31:0] ema,
                             input logic eiv, input logic [31:0] einst, input logic [31:0] eipc);
    vec_t r;
    r.rdy = rdy; r.rv = rv; r.rd = rd; r.re = re; r.ir = ir; r.xv = xv; r.xpc = xpc;
    r.e_mv = emv; r.e_ma = ema; r.e_iv = eiv; r.e_inst = einst; r.e_ipc = eipc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rd, input logic re,
                     input logic ir, input logic xv, input logic [31:0] xpc);
    @(negedge clk);
    bus.mem_req_ready  = rdy;
    bus.mem_rsp_valid  = rv;
    bus.mem_rsp_data   = rd;
    bus.mem_rsp_err    = re;
    bus.inst_ready     = ir;
    bus.redirect_valid = xv;
    bus.redirect_pc    = xpc;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    bus.mem_rsp_err = 1'b0; bus.inst_ready = 1'b0; bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    #1;
    chk("rst_mvalid", bus.mem_req_valid, 0);
    chk("rst_addr",   bus.mem_req_addr, 32'h8000_0000);
    chk("rst_ivalid", bus.inst_valid, 0);
    chk("rst_inst",   bus.inst, 0);
    chk("rst_ipc",    bus.inst_pc, 0);
    chk("rst_fault",  bus.fetch_fault, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_mvalid", bus.mem_req_valid, 0);
  endtask

  vec_t tbl[22];

  initial begin
    tbl[0]  = v(1,0,32'h0,0,0,0,32'h0,                  1,32'h8000_0000, 0,32'h0,32'h0);
    tbl[1]  = v(0,1,32'h0000_0513,0,0,0,32'h0,          0,32'h0, 0,32'h0,32'h0);
    tbl[2]  = v(0,0,32'h0,0,1,0,32'h0,                  0,32'h0, 1,32'h0000_0513,32'h8000_0000);
    tbl[3]  = v(1,0,32'h0,0,0,0,32'h0,                  1,32'h8000_0004, 0,32'h0,32'h0);
    tbl[4]  = v(0,0,32'h0,0,0,1,32'h8000_0100,          0,32'h0, 0,32'h0,32'h0);
    tbl[5]  = v(0,1,32'h0000_0093,0,0,0,32'h0,          0,32'h0, 0,32'h0,32'h0);
    tbl[6]  = v(0,0,32'h0,0,0,1,32'h8000_0200,          1,32'h8000_0100, 0,32'h0,32'h0);
    tbl[7]  = v(1,0,32'h0,0,0,1,32'h8000_0300,          1,32'h8000_0200, 0,32'h0,32'h0);
    tbl[8]  = v(0,1,32'h1111_1111,1,0,0,32'h0,          0,32'h0, 0,32'h0,32'h0);
    tbl[9]  = v(1,0,32'h0,0,0,0,32'h0,                  1,32'h8000_0300, 0,32'h0,32'h0);
    tbl[10] = v(0,1,32'h2222_2222,0,0,1,32'h8000_0400,  0,32'h0, 0,32'h0,32'h0);
    tbl[11] = v(1,0,32'h0,0,0,0,32'h0,                  1,32'h8000_0400, 0,32'h0,32'h0);
    tbl[12] = v(0,1,32'h3333_3333,0,0,0,32'h0,          0,32'h0, 0,32'h0,32'h0);
    tbl[13] = v(0,0,32'h0,0,1,1,32'h8000_0500,          0,32'h0, 1,32'h3333_3333,32'h8000_0400);
    tbl[14] = v(1,0,32'h0,0,0,0,32'h0,                  1,32'h8000_0500, 0,32'h0,32'h0);
    tbl[15] = v(0,1,32'h4444_4444,0,0,0,32'h0,          0,32'h0, 0,32'h0,32'h0);
    tbl[16] = v(0,0,32'h0,0,0,1,32'h8000_0600,          0,32'h0, 1,32'h4444_4444,32'h8000_0500);
    tbl[17] = v(0,1,32'h5555_5555,0,0,0,32'h0,          1,32'h8000_0600, 0,32'h0,32'h0);
    tbl[18] = v(1,0,32'h0,0,0,0,32'h0,                  1,32'h8000_0600, 0,32'h0,32'h0);
    tbl[19] = v(0,1,32'h6666_6666,0,0,0,32'h0,          0,32'h0, 0,32'h0,32'h0);
    tbl[20] = v(0,0,32'h0,0,1,0,32'h0,                  0,32'h0, 1,32'h6666_6666,32'h8000_0600);
    tbl[21] = v(0,0,32'h0,0,0,0,32'h0,                  1,32'h8000_0604, 0,32'h0,32'h0);

    do_reset();
    for (int i = 0; i < 22; i++) begin
      cyc(tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].re, tbl[i].ir, tbl[i].xv, tbl[i].xpc);
      chk($sformatf("v%0d_mvalid", i), bus.mem_req_valid, tbl[i].e_mv);
      chk($sformatf("v%0d_ivalid", i), bus.inst_valid, tbl[i].e_iv);
      chk($sformatf("v%0d_fault", i),  bus.fetch_fault, 0);
      if (tbl[i].e_mv) chk($sformatf("v%0d_addr", i), bus.mem_req_addr, tbl[i].e_ma);
      if (tbl[i].e_iv) begin
        chk($sformatf("v%0d_inst", i), bus.inst, tbl[i].e_inst);
        chk($sformatf("v%0d_ipc", i),  bus.inst_pc, tbl[i].e_ipc);
      end
    end

    // Decode stall: HOLD keeps its word and no new request goes out.
    do_reset();
    cyc(1,0,0,0,0,0,0);  chk("st_addr0", bus.mem_req_addr, 32'h8000_0000);
    cyc(0,1,32'h0000_0513,0,0,0,0);
    for (int i = 0; i < 5; i++) begin
      cyc(1,0,0,0,0,0,0);
      chk("st_ivalid", bus.inst_valid, 1);
      chk("st_inst",   bus.inst, 32'h0000_0513);
      chk("st_ipc",    bus.inst_pc, 32'h8000_0000);
      chk("st_mvalid", bus.mem_req_valid, 0);
    end
    cyc(0,0,0,0,1,0,0);  chk("st_ivalid_hs", bus.inst_valid, 1);
    cyc(0,0,0,0,0,0,0);  chk("st_next_mv", bus.mem_req_valid, 1);
                         chk("st_next_addr", bus.mem_req_addr, 32'h8000_0004);
                         chk("st_next_iv", bus.inst_valid, 0);
    cyc(1,0,0,0,0,0,0);  chk("st_next_mv2", bus.mem_req_valid, 1);
    cyc(0,0,0,0,0,0,0);  chk("st_one_req", bus.mem_req_valid, 0);

    // Address wrap at the top of the space.
    do_reset();
    cyc(0,0,0,0,0,1,32'hFFFF_FFFC); chk("wr_addr_old", bus.mem_req_addr, 32'h8000_0000);
    cyc(1,0,0,0,0,0,0);             chk("wr_addr_top", bus.mem_req_addr, 32'hFFFF_FFFC);
    cyc(0,1,32'hAAAA_5555,0,0,0,0);
    cyc(0,0,0,0,1,0,0);             chk("wr_ipc", bus.inst_pc, 32'hFFFF_FFFC);
    cyc(0,0,0,0,0,0,0);             chk("wr_mvalid", bus.mem_req_valid, 1);
                                    chk("wr_addr0", bus.mem_req_addr, 32'h0000_0000);

    // Misaligned redirect: fault, no requests, redirects ignored until reset.
    cyc(0,0,0,0,0,1,32'h8000_0203); chk("mis_pre_mv", bus.mem_req_valid, 1);
    cyc(1,0,0,0,0,1,32'h8000_0000); chk("mis_fault", bus.fetch_fault, 1);
                                    chk("mis_mvalid", bus.mem_req_valid, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1,0,0,0,1,1,32'h8000_0000);
      chk("mis_hold_fault", bus.fetch_fault, 1);
      chk("mis_hold_mv", bus.mem_req_valid, 0);
      chk("mis_hold_iv", bus.inst_valid, 0);
    end
    do_reset();
    cyc(1,0,0,0,0,0,0);  chk("mis_rst_mv", bus.mem_req_valid, 1);
                         chk("mis_rst_addr", bus.mem_req_addr, 32'h8000_0000);

    // Error response on the first fetch.
    cyc(0,1,32'h0,1,0,0,0); chk("err_wait_mv", bus.mem_req_valid, 0);
    cyc(0,0,0,0,0,0,0);     chk("err_fault", bus.fetch_fault, 1);
                            chk("err_iv", bus.inst_valid, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1,0,0,0,0,1,32'h8000_0000);
      chk("err_redir_mv", bus.mem_req_valid, 0);
      chk("err_redir_ff", bus.fetch_fault, 1);
    end

    // Reset mid-transaction, then a stale response in REQ.
    do_reset();
    cyc(1,0,0,0,0,0,0);  chk("mid_mv", bus.mem_req_valid, 1);
    cyc(0,0,0,0,0,0,0);  chk("mid_wait_mv", bus.mem_req_valid, 0);
    do_reset();
    cyc(0,1,32'hDEAD_BEEF,0,0,0,0); chk("stale_mv", bus.mem_req_valid, 1);
                                    chk("stale_addr", bus.mem_req_addr, 32'h8000_0000);
                                    chk("stale_iv", bus.inst_valid, 0);
    cyc(0,0,0,0,0,0,0);  chk("stale_iv2", bus.inst_valid, 0);
                         chk("stale_mv2", bus.mem_req_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
